morse_tx_encoder: RTL and testbench

MORSE_TX_ENCODER -- requirements
Module: morse_tx_encoder

---
 rtl/morse_tx_encoder.sv | 172 +++++++++++++++++
 tb/tb_morse_tx_encoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/morse_tx_encoder.sv
// Morse key encoder: sends one letter (A..Z) as timed marks/gaps on Tone,
// followed by the inter-letter gap, then pulses Done.
module morse_tx_encoder #(
    parameter int unsigned UNIT_CYCLES = 12_000_000
) (
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Abort,
    input  logic [4:0] Letter,
    output logic       Tone,
    output logic       Busy,
    output logic       Done,
    output logic       Err,
    output logic [4:0] Cur_letter
);

    localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] UNIT_MAX = CW'(UNIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MARK, GAP, LGAP} state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] unit_q, unit_n;
    logic [1:0]    mult_q, mult_n;
    logic [1:0]    idx_q, idx_n;
    logic [1:0]    last_q, last_n;
    logic [3:0]    pat_q, pat_n;
    logic [4:0]    cur_n;
    logic          done_n, err_n, unit_end;

    // Pattern ROM: {last symbol index, symbols left-aligned, 1=dash}
    function automatic logic [5:0] rom(input logic [4:0] l);
        case (l)
            5'd0:  rom = {2'd1, 4'b0100};
            5'd1:  rom = {2'd3, 4'b1000};
            5'd2:  rom = {2'd3, 4'b1010};
            5'd3:  rom = {2'd2, 4'b1000};
            5'd4:  rom = {2'd0, 4'b0000};
            5'd5:  rom = {2'd3, 4'b0010};
            5'd6:  rom = {2'd2, 4'b1100};
            5'd7:  rom = {2'd3, 4'b0000};
            5'd8:  rom = {2'd1, 4'b0000};
            5'd9:  rom = {2'd3, 4'b0111};
            5'd10: rom = {2'd2, 4'b1010};
            5'd11: rom = {2'd3, 4'b0100};
            5'd12: rom = {2'd1, 4'b1100};
            5'd13: rom = {2'd1, 4'b1000};
            5'd14: rom = {2'd2, 4'b1110};
            5'd15: rom = {2'd3, 4'b0110};
            5'd16: rom = {2'd3, 4'b1101};
            5'd17: rom = {2'd2, 4'b0100};
            5'd18: rom = {2'd2, 4'b0000};
            5'd19: rom = {2'd0, 4'b1000};
            5'd20: rom = {2'd2, 4'b0010};
            5'd21: rom = {2'd3, 4'b0001};
            5'd22: rom = {2'd2, 4'b0110};
            5'd23: rom = {2'd3, 4'b1001};
            5'd24: rom = {2'd3, 4'b1011};
            5'd25: rom = {2'd3, 4'b1100};
            default: rom = 6'd0;
        endcase
    endfunction

    assign unit_end = (unit_q == UNIT_MAX);

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            unit_q     <= '0;
            mult_q     <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            pat_q      <= '0;
            Cur_letter <= '0;
            Tone       <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
        end else begin
            state_q    <= state_n;
            unit_q     <= unit_n;
            mult_q     <= mult_n;
            idx_q      <= idx_n;
            last_q     <= last_n;
            pat_q      <= pat_n;
            Cur_letter <= cur_n;
            Tone       <= (state_n == MARK);
            Busy       <= (state_n != IDLE);
            Done       <= done_n;
            Err        <= err_n;
        end
    end

    always_comb begin
        state_n = state_q;
        unit_n  = unit_q;
        mult_n  = mult_q;
        idx_n   = idx_q;
        last_n  = last_q;
        pat_n   = pat_q;
        cur_n   = Cur_letter;
        done_n  = 1'b0;
        err_n   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start && !Abort) begin
                    if (Letter <= 5'd25) begin
                        state_n          = MARK;
                        cur_n            = Letter;
                        {last_n, pat_n}  = rom(Letter);
                        unit_n           = '0;
                        mult_n           = '0;
                        idx_n            = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            MARK: begin
                if (!unit_end) begin
                    unit_n = unit_q + CW'(1);
                end else begin
                    unit_n = '0;
                    // a dash spans three units, a dot one
                    if (mult_q == (pat_q[3] ? 2'd2 : 2'd0)) begin
                        mult_n  = '0;
                        state_n = (idx_q == last_q) ? LGAP : GAP;
                    end else begin
                        mult_n = mult_q + 2'd1;
                    end
                end
            end
            GAP: begin
                if (!unit_end) begin
                    unit_n = unit_q + CW'(1);
                end else begin
                    unit_n  = '0;
                    idx_n   = idx_q + 2'd1;
                    pat_n   = {pat_q[2:0], 1'b0};
                    state_n = MARK;
                end
            end
            LGAP: begin
                if (!unit_end) begin
                    unit_n = unit_q + CW'(1);
                end else begin
                    unit_n = '0;
                    if (mult_q == 2'd2) begin
                        mult_n  = '0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        mult_n = mult_q + 2'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Abort cancels any transmission without a Done pulse
        if (Abort && state_q != IDLE) begin
            state_n = IDLE;
            unit_n  = '0;
            mult_n  = '0;
            idx_n   = '0;
            done_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_morse_tx_encoder.sv
// Bench for morse_tx_encoder: queue-based waveform model plus directed
// literal checks and randomized letter/abort traffic.
module tb_morse_tx_encoder;

    localparam int unsigned U = 4;

    logic       board_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Abort = 1'b0;
    logic [4:0] Letter = 5'd0;
    logic       Tone, Busy, Done, Err;
    logic [4:0] Cur_letter;

    int total = 0;
    int bad = 0;

    morse_tx_encoder #(.UNIT_CYCLES(U)) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .Start     (Start),
        .Abort     (Abort),
        .Letter    (Letter),
        .Tone      (Tone),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .Cur_letter(Cur_letter)
    );

    always #5 board_clk = ~board_clk;

    string morse [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                          "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                          "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                          "-.--", "--.."};

    // Model: queue of Tone values for every remaining busy cycle
    logic       q [$];
    logic       m_tone = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic [4:0] m_cur = 5'd0;

    task automatic build(input int l);
        string s;
        s = morse[l];
        q.delete();
        for (int i = 0; i < s.len(); i++) begin
            int n;
            n = (s[i] == "-") ? 3 : 1;
            repeat (n * U) q.push_back(1'b1);
            if (i < s.len() - 1) repeat (U) q.push_back(1'b0);
        end
        repeat (3 * U) q.push_back(1'b0);
    endtask

    always @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            q.delete();
            m_tone = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cur = 5'd0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_busy) begin
                if (Abort) begin
                    q.delete();
                    m_tone = 1'b0; m_busy = 1'b0;
                end else if (q.size() > 0) begin
                    m_tone = q.pop_front();
                end else begin
                    m_tone = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                end
            end else if (Start && !Abort) begin
                if (int'(Letter) <= 25) begin
                    m_cur = Letter;
                    build(int'(Letter));
                    m_tone = q.pop_front();
                    m_busy = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge board_clk) begin
        if (!Reset) begin
            chk("model_tone", 32'(Tone), 32'(m_tone));
            chk("model_busy", 32'(Busy), 32'(m_busy));
            chk("model_done", 32'(Done), 32'(m_done));
            chk("model_err",  32'(Err),  32'(m_err));
            chk("model_cur",  32'(Cur_letter), 32'(m_cur));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge board_clk);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (Busy && c < 300) begin
            tick(1);
            c++;
        end
        chk("idle_timeout", 32'(Busy), 32'd0);
    endtask

    task automatic send(input logic [4:0] l);
        Start = 1'b1; Letter = l;
        tick(1);
        Start = 1'b0;
    endtask

    initial begin
        tick(2);
        Reset = 1'b0;
        tick(1);
        chk("rst_tone", 32'(Tone), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_cur",  32'(Cur_letter), 32'd0);

        // E, then T started in E's Done cycle
        send(5'd4);                              // now k+1
        chk("e_tone_k1", 32'(Tone), 32'd1);
        chk("e_busy_k1", 32'(Busy), 32'd1);
        tick(3); chk("e_tone_k4", 32'(Tone), 32'd1);
        tick(1); chk("e_tone_k5", 32'(Tone), 32'd0);
        tick(11); chk("e_busy_k16", 32'(Busy), 32'd1);
        chk("e_done_k16", 32'(Done), 32'd0);
        tick(1); chk("e_done_k17", 32'(Done), 32'd1);
        chk("e_busy_k17", 32'(Busy), 32'd0);
        send(5'd19);                             // k+18
        chk("b2b_busy", 32'(Busy), 32'd1);
        chk("b2b_tone", 32'(Tone), 32'd1);
        chk("b2b_cur",  32'(Cur_letter), 32'd19);
        wait_idle();
        tick(2);

        // A timing
        send(5'd0);
        chk("a_tone_k1", 32'(Tone), 32'd1);
        tick(3); chk("a_tone_k4", 32'(Tone), 32'd1);
        tick(1); chk("a_tone_k5", 32'(Tone), 32'd0);
        tick(4); chk("a_tone_k9", 32'(Tone), 32'd1);
        tick(11); chk("a_tone_k20", 32'(Tone), 32'd1);
        tick(1); chk("a_tone_k21", 32'(Tone), 32'd0);
        tick(11); chk("a_done_k32", 32'(Done), 32'd0);
        chk("a_busy_k32", 32'(Busy), 32'd1);
        tick(1); chk("a_done_k33", 32'(Done), 32'd1);
        tick(2);

        // Illegal letter
        send(5'd26);
        chk("err_k1", 32'(Err), 32'd1);
        chk("err_busy", 32'(Busy), 32'd0);
        chk("err_cur", 32'(Cur_letter), 32'd0);
        tick(1); chk("err_k2", 32'(Err), 32'd0);

        // T with ignored Start, then Abort
        send(5'd19);                             // k+1
        tick(2);                                 // k+3
        send(5'd5);                              // k+4
        chk("ign_cur", 32'(Cur_letter), 32'd19);
        tick(2);                                 // k+6
        Abort = 1'b1;
        tick(1);                                 // k+7
        Abort = 1'b0;
        chk("abort_tone", 32'(Tone), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_cur", 32'(Cur_letter), 32'd19);
        tick(40);

        // Abort beats Start in IDLE
        Abort = 1'b1;
        send(5'd27);
        Abort = 1'b0;
        chk("ab_st_err", 32'(Err), 32'd0);
        chk("ab_st_busy", 32'(Busy), 32'd0);
        tick(2);

        // Reset in the middle of Q's first dash
        send(5'd16);
        tick(4);
        chk("q_tone_pre", 32'(Tone), 32'd1);
        #1 Reset = 1'b1;
        #1;
        chk("q_rst_tone", 32'(Tone), 32'd0);
        chk("q_rst_busy", 32'(Busy), 32'd0);
        chk("q_rst_cur", 32'(Cur_letter), 32'd0);
        tick(1);
        Reset = 1'b0;
        tick(60);
        send(5'd4);
        chk("post_rst_start", 32'(Busy), 32'd1);
        wait_idle();

        // Random traffic
        for (int i = 0; i < 5000; i++) begin
            Start  = ($urandom % 4) == 0;
            Letter = (($urandom % 8) == 0) ? 5'(26 + $urandom % 6) : 5'($urandom % 26);
            Abort  = ($urandom % 300) == 0;
            tick(1);
        end
        Start = 1'b0;
        Abort = 1'b0;
        tick(1);
        wait_idle();
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
